cluster_rst_cken_seq: RTL and testbench
=======================================

// Module: cluster_rst_cken_seq
// PURPOSE
//  Chip-level sequencer feeding cluster clock headers: owns per-cluster cluster_cken,
//  the global grst_l and the global gdbginit_l.
//  After power-on reset it staggers cluster clock enables to limit di/dt.
//  It then holds reset long enough for the headers' reset synchronizers and releases it.
//  In run mode it services warm-reset and debug-init requests and per-cluster clock gating.
// PARAMETERS
//  NUM_CLUSTERS  4   number of cluster headers driven
//  STAGGER       4   gclk cycles between successive cluster_cken rises at power-up (>=1)
//  RST_HOLD      16  cycles grst_l/gdbginit_l held low after clocks are on (>=4)
//  DBG_HOLD      8   cycles gdbginit_l held low for a debug-init request (>=4)
//  CNT_W         8   counter width; 2**CNT_W > max(STAGGER,RST_HOLD,DBG_HOLD)
// PORTS
//  gclk          in   1             global clock
//  arst_l        in   1             asynchronous active-low reset
//  wrm_rst_req   in   1             warm-reset request, single-cycle pulse, gclk domain
//  dbginit_req   in   1             debug-init request, single-cycle pulse, gclk domain
//  cken_req      in   NUM_CLUSTERS  run-mode per-cluster clock enable request
//  cluster_cken  out  NUM_CLUSTERS  clock enable to each cluster header
//  grst_l        out  1             global sync reset to headers, active low
//  gdbginit_l    out  1             global debug init to headers, active low
//  seq_done      out  1             1 while in RUN or DBG (chip out of reset)
//  busy          out  1             1 in any state other than RUN; requests ignored
// BEHAVIOUR
//  - Reset: arst_l low -> state PWRUP, cluster_cken=0, grst_l=0, gdbginit_l=0,
//    seq_done=0, busy=1, counters 0. All outputs are flop outputs (no comb paths).
//  - Cycle numbering: cycle 0 = first gclk posedge with arst_l high. PWRUP -> RAMP at cycle 0.
//  - RAMP: cluster_cken[i] rises at cycle (i+1)*STAGGER and stays high. Index ascends 0..N-1.
//    After cken[N-1] rises, go to HOLD. grst_l and gdbginit_l remain 0 throughout.
//  - HOLD: counts RST_HOLD cycles. grst_l and gdbginit_l rise together at cycle
//    N*STAGGER+RST_HOLD, and seq_done=1, busy=0 in the same cycle. State -> RUN.
//  - RUN: cluster_cken <= cken_req (1-cycle registered latency).
//    - wrm_rst_req -> WRST next cycle; dbginit_req -> DBG next cycle.
//    - Both in the same cycle: WRST wins; dbginit_req is dropped, since WRST already pulses gdbginit_l.
//  - WRST: grst_l=0, gdbginit_l=0, seq_done=0, busy=1 for RST_HOLD cycles.
//    cluster_cken forced all-ones so every cluster observes reset.
//    On exit: grst_l=gdbginit_l=1, seq_done=1, back to RUN. cken reloads cken_req on the next cycle.
//  - DBG: gdbginit_l=0 for DBG_HOLD cycles, grst_l stays 1, seq_done stays 1, busy=1.
//    cluster_cken keeps tracking cken_req. Returns to RUN with gdbginit_l=1.
//  - Request pulses arriving while busy=1 are ignored (not queued).
//    A request on the exact cycle of return to RUN is ignored (busy still 1 that cycle).
//  - Counters saturate-free: each count restarts at 0 on state entry, compares to PARAM-1.
//  - arst_l assertion mid-sequence (any state): immediate return to reset values, full
//    power-up sequence reruns after release.
//  - Outputs change only on gclk posedge except on async reset assertion.
// TESTING
//  1. Power-up, defaults -> cluster_cken 0001@4, 0011@8, 0111@12, 1111@16.
//     grst_l=gdbginit_l=1 and seq_done=1 at cycle 32.
//  2. RUN, cken_req=4'b0101 at cycle 40 -> cluster_cken=0101 at cycle 41.
//     Then wrm_rst_req pulse at 50 -> grst_l=0, cken=1111 cycles 51..66.
//     Release at 67; cken=0101 at 68.
//  3. RUN, dbginit_req at cycle 40 -> gdbginit_l=0 cycles 41..48, grst_l stays 1, seq_done stays 1.
//  4. wrm_rst_req and dbginit_req same cycle -> only WRST (RST_HOLD low, both lines);
//     no DBG follows. dbginit_req during WRST -> ignored.
//  5. arst_l low at cycle 10 (mid-RAMP) for 3 cycles -> all outputs 0 immediately;
//     after release, cken[0] rises 4 cycles later.
//  6. NUM_CLUSTERS=1, STAGGER=1, RST_HOLD=4 -> cken at 1, grst_l high at 5; checks boundary counts.

Source files
------------

// File: rtl/cluster_rst_cken_seq.sv
// Power-up/warm-reset sequencer for cluster clock headers: staggers cluster_cken, then times grst_l/gdbginit_l.
// Every output is a flop. Requests take effect one gclk later and are dropped (not queued) while busy is high.
module cluster_rst_cken_seq #(
  parameter int NUM_CLUSTERS = 4,
  parameter int STAGGER      = 4,
  parameter int RST_HOLD     = 16,
  parameter int DBG_HOLD     = 8,
  parameter int CNT_W        = 8
) (
  input  logic                    gclk,
  input  logic                    arst_l,
  input  logic                    wrm_rst_req,
  input  logic                    dbginit_req,
  input  logic [NUM_CLUSTERS-1:0] cken_req,
  output logic [NUM_CLUSTERS-1:0] cluster_cken,
  output logic                    grst_l,
  output logic                    gdbginit_l,
  output logic                    seq_done,
  output logic                    busy
);

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    RAMP  = 3'd1,
    HOLD  = 3'd2,
    RUN   = 3'd3,
    WRST  = 3'd4,
    DBG   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]        STAGGER_LAST = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0]        RST_LAST     = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]        DBG_LAST     = CNT_W'(DBG_HOLD - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE      = CNT_W'(1);
  localparam logic [NUM_CLUSTERS-1:0] CKEN_ONE     = NUM_CLUSTERS'(1);
  localparam logic [NUM_CLUSTERS-1:0] CKEN_ALL     = '1;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_CLUSTERS-1:0] ramp_nxt;

  // Enables fill from bit 0 upward; the ramp is finished once the top bit is set.
  assign ramp_nxt = (cluster_cken << 1) | CKEN_ONE;

  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      state        <= PWRUP;
      cnt          <= '0;
      cluster_cken <= '0;
      grst_l       <= 1'b0;
      gdbginit_l   <= 1'b0;
      seq_done     <= 1'b0;
      busy         <= 1'b1;
    end else begin
      case (state)
        PWRUP: begin
          state <= RAMP;
          cnt   <= '0;
        end

        RAMP: begin
          if (cnt == STAGGER_LAST) begin
            cnt          <= '0;
            cluster_cken <= ramp_nxt;
            if (ramp_nxt[NUM_CLUSTERS-1]) state <= HOLD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        HOLD: begin
          if (cnt == RST_LAST) begin
            cnt        <= '0;
            grst_l     <= 1'b1;
            gdbginit_l <= 1'b1;
            seq_done   <= 1'b1;
            busy       <= 1'b0;
            state      <= RUN;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        RUN: begin
          cnt          <= '0;
          cluster_cken <= cken_req;
          // Warm reset also pulses gdbginit_l, so a simultaneous debug-init is redundant.
          if (wrm_rst_req) begin
            state        <= WRST;
            cluster_cken <= CKEN_ALL;
            grst_l       <= 1'b0;
            gdbginit_l   <= 1'b0;
            seq_done     <= 1'b0;
            busy         <= 1'b1;
          end else if (dbginit_req) begin
            state      <= DBG;
            gdbginit_l <= 1'b0;
            busy       <= 1'b1;
          end
        end

        WRST: begin
          cluster_cken <= CKEN_ALL;
          if (cnt == RST_LAST) begin
            cnt        <= '0;
            grst_l     <= 1'b1;
            gdbginit_l <= 1'b1;
            seq_done   <= 1'b1;
            busy       <= 1'b0;
            state      <= RUN;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        DBG: begin
          cluster_cken <= cken_req;
          if (cnt == DBG_LAST) begin
            cnt        <= '0;
            gdbginit_l <= 1'b1;
            busy       <= 1'b0;
            state      <= RUN;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= PWRUP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_rst_cken_seq.sv
// Directed-vector bench for cluster_rst_cken_seq: default build plus a 1-cluster minimum-count build.
module tb_cluster_rst_cken_seq;

  logic       gclk = 1'b0;
  logic       arst_l;
  logic       wrm_rst_req;
  logic       dbginit_req;
  logic [3:0] cken_req;
  logic [3:0] cluster_cken;
  logic       grst_l, gdbginit_l, seq_done, busy;

  logic       wrm_s = 1'b0;
  logic       dbg_s = 1'b0;
  logic [0:0] cken_req_s = 1'b1;
  logic [0:0] cken_s;
  logic       grst_s, gdbg_s, done_s, busy_s;

  int errors = 0;
  int checks = 0;

  always #5 gclk = ~gclk;

  cluster_rst_cken_seq dut (
    .gclk(gclk), .arst_l(arst_l), .wrm_rst_req(wrm_rst_req), .dbginit_req(dbginit_req),
    .cken_req(cken_req), .cluster_cken(cluster_cken), .grst_l(grst_l),
    .gdbginit_l(gdbginit_l), .seq_done(seq_done), .busy(busy)
  );

  cluster_rst_cken_seq #(.NUM_CLUSTERS(1), .STAGGER(1), .RST_HOLD(4), .DBG_HOLD(4), .CNT_W(8)) dut_s (
    .gclk(gclk), .arst_l(arst_l), .wrm_rst_req(wrm_s), .dbginit_req(dbg_s),
    .cken_req(cken_req_s), .cluster_cken(cken_s), .grst_l(grst_s),
    .gdbginit_l(gdbg_s), .seq_done(done_s), .busy(busy_s)
  );

  logic [7:0] main_out, small_out;
  assign main_out  = {cluster_cken, grst_l, gdbginit_l, seq_done, busy};
  assign small_out = {3'b000, cken_s, grst_s, gdbg_s, done_s, busy_s};

  typedef struct {
    int         cyc;
    logic [3:0] req;
    logic       wrm;
    logic       dbg;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {cken, grst_l, gdbginit_l, seq_done, busy} for the 1-cluster build, cycles 0..6
  logic [7:0] small_exp [0:6] = '{8'h01, 8'h11, 8'h11, 8'h11, 8'h11, 8'h1E, 8'h1E};

  function automatic logic [7:0] pk(logic [3:0] ck, logic g, logic d, logic sd, logic b);
    return {ck, g, d, sd, b};
  endfunction

  task automatic add(int c, logic [3:0] r, logic w, logic d, logic [7:0] e);
    vec_t v;
    v.cyc = c; v.req = r; v.wrm = w; v.dbg = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
    wrm_rst_req = 1'b0;
    dbginit_req = 1'b0;
  endtask

  task automatic do_reset();
    arst_l = 1'b0;
    repeat (2) @(posedge gclk);
    #2;
    arst_l = 1'b1;
  endtask

  initial begin
    int vi;
    arst_l      = 1'b0;
    wrm_rst_req = 1'b0;
    dbginit_req = 1'b0;
    cken_req    = 4'b1111;

    // Power-up ramp, hold, run-mode tracking, warm reset, debug init and collisions.
    add(0,   4'b1111, 0, 0, pk(4'b0000, 0, 0, 0, 1));
    add(3,   4'b1111, 0, 0, pk(4'b0000, 0, 0, 0, 1));
    add(4,   4'b1111, 0, 0, pk(4'b0001, 0, 0, 0, 1));
    add(7,   4'b1111, 0, 0, pk(4'b0001, 0, 0, 0, 1));
    add(8,   4'b1111, 0, 0, pk(4'b0011, 0, 0, 0, 1));
    add(12,  4'b1111, 0, 0, pk(4'b0111, 0, 0, 0, 1));
    add(15,  4'b1111, 0, 0, pk(4'b0111, 0, 0, 0, 1));
    add(16,  4'b1111, 0, 0, pk(4'b1111, 0, 0, 0, 1));
    add(31,  4'b1111, 0, 0, pk(4'b1111, 0, 0, 0, 1));
    add(32,  4'b1111, 0, 0, pk(4'b1111, 1, 1, 1, 0));
    add(33,  4'b1111, 0, 0, pk(4'b1111, 1, 1, 1, 0));
    add(40,  4'b0101, 0, 0, pk(4'b1111, 1, 1, 1, 0));
    add(41,  4'b0101, 0, 0, pk(4'b0101, 1, 1, 1, 0));
    add(50,  4'b0101, 1, 0, pk(4'b0101, 1, 1, 1, 0));
    add(51,  4'b0101, 0, 0, pk(4'b1111, 0, 0, 0, 1));
    add(52,  4'b0101, 0, 1, pk(4'b1111, 0, 0, 0, 1));
    add(60,  4'b0101, 0, 0, pk(4'b1111, 0, 0, 0, 1));
    add(66,  4'b0101, 1, 0, pk(4'b1111, 0, 0, 0, 1));
    add(67,  4'b0101, 0, 0, pk(4'b1111, 1, 1, 1, 0));
    add(68,  4'b0101, 0, 0, pk(4'b0101, 1, 1, 1, 0));
    add(69,  4'b0101, 0, 0, pk(4'b0101, 1, 1, 1, 0));
    add(70,  4'b0101, 0, 1, pk(4'b0101, 1, 1, 1, 0));
    add(71,  4'b0011, 0, 0, pk(4'b0101, 1, 0, 1, 1));
    add(72,  4'b0011, 0, 0, pk(4'b0011, 1, 0, 1, 1));
    add(75,  4'b0011, 1, 0, pk(4'b0011, 1, 0, 1, 1));
    add(76,  4'b0011, 0, 0, pk(4'b0011, 1, 0, 1, 1));
    add(78,  4'b0011, 0, 1, pk(4'b0011, 1, 0, 1, 1));
    add(79,  4'b0011, 0, 0, pk(4'b0011, 1, 1, 1, 0));
    add(80,  4'b0011, 1, 1, pk(4'b0011, 1, 1, 1, 0));
    add(81,  4'b0011, 0, 0, pk(4'b1111, 0, 0, 0, 1));
    add(96,  4'b0011, 0, 0, pk(4'b1111, 0, 0, 0, 1));
    add(97,  4'b0011, 0, 0, pk(4'b1111, 1, 1, 1, 0));
    add(98,  4'b0011, 0, 0, pk(4'b0011, 1, 1, 1, 0));
    add(100, 4'b0011, 0, 0, pk(4'b0011, 1, 1, 1, 0));

    repeat (2) @(posedge gclk);
    #1;
    check("reset_main",  main_out,  pk(4'b0000, 0, 0, 0, 1));
    check("reset_small", small_out, 8'h01);

    do_reset();
    vi = 0;
    for (int c = 0; c <= 100; c++) begin
      tick();
      if (c <= 6) check($sformatf("small_cyc%0d", c), small_out, small_exp[c]);
      if (vi < vecs.size() && vecs[vi].cyc == c) begin
        check($sformatf("main_cyc%0d", c), main_out, vecs[vi].exp);
        cken_req    = vecs[vi].req;
        wrm_rst_req = vecs[vi].wrm;
        dbginit_req = vecs[vi].dbg;
        vi++;
      end
    end

    // Async reset in the middle of the ramp, then a full rerun of the power-up sequence.
    cken_req = 4'b1111;
    do_reset();
    for (int c = 0; c <= 10; c++) tick();
    check("ramp_cyc10", main_out, pk(4'b0011, 0, 0, 0, 1));
    #2;
    arst_l = 1'b0;
    #1;
    check("async_main",  main_out,  pk(4'b0000, 0, 0, 0, 1));
    check("async_small", small_out, 8'h01);
    repeat (3) @(posedge gclk);
    #1;
    check("async_hold", main_out, pk(4'b0000, 0, 0, 0, 1));
    #1;
    arst_l = 1'b1;
    for (int c = 0; c <= 3; c++) tick();
    check("rerun_cyc3", main_out, pk(4'b0000, 0, 0, 0, 1));
    tick();
    check("rerun_cyc4", main_out, pk(4'b0001, 0, 0, 0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
